pivot_fault_store: RTL and testbench
====================================

# pivot_fault_store

Fault-collection front end of the BIRA datapath. Accepts fault reports (row, column, bank) from the BIST engine and classifies each one. A fault is a new pivot entry, or a non-pivot that shares a row or column with a stored pivot in the same bank, or a duplicate. After the test ends, the block streams the stored pivot entries over a valid/ready port to the row/column candidate comparators. Bank code 2'b00 means "empty/invalid" throughout; the downstream comparators rely on this.

## Interface
- DEPTH, 8, number of pivot entries (2..16)
- ADDR_W, 10, row and column address width
- BNK_W, 2, bank field width; value 0 is reserved for empty
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- col_start  in  1  one-cycle pulse: clear all entries and flags, enter COLLECT
- flt_valid  in  1  fault report valid
- flt_ready  out  1  fault report accepted (high only in COLLECT)
- flt_row  in  ADDR_W  faulty row
- flt_col  in  ADDR_W  faulty column
- flt_bnk  in  BNK_W  faulty bank
- flt_end  in  1  BIST finished; sampled only in COLLECT
- np_valid  out  1  one-cycle pulse: non-pivot fault classified
- np_idx  out  $clog2(DEPTH)  lowest matching pivot index
- np_row, np_col  out  ADDR_W  non-pivot address
- np_bnk  out  BNK_W  non-pivot bank
- pv_valid  out  1  pivot entry valid on readout port
- pv_ready  in  1  downstream accepts entry
- pv_row, pv_col  out  ADDR_W  pivot address
- pv_bnk  out  BNK_W  pivot bank
- pv_last  out  1  current entry is the final one
- pv_cnt  out  $clog2(DEPTH+1)  stored pivot count
- overflow  out  1  sticky: new pivot arrived while full (unrepairable)
- busy  out  1  state is COLLECT or DRAIN
- done  out  1  state is DONE

## Operation
- States: IDLE, COLLECT, DRAIN, DONE. Reset lands in IDLE.
- col_start in any state has priority over everything else. It clears pv_cnt, overflow, and all entry bank fields to 0, and moves the FSM to COLLECT.
- COLLECT: flt_ready=1. On accept (flt_valid&&flt_ready), the fault is compared against entries 0..pv_cnt-1 using the current registered array:
  - flt_bnk==0: dropped with no effect.
  - Exact match on row, column and bank: duplicate; dropped, no np pulse.
  - Row match or column match, with equal bank: non-pivot. np_valid pulses, np_idx = lowest matching index, np_* carry the fault.
  - Otherwise, if pv_cnt<DEPTH: write the fault to entry pv_cnt and increment pv_cnt.
  - Otherwise (full): set overflow and drop the fault.
- flt_end in COLLECT moves the FSM to DRAIN. A fault accepted in the same cycle is classified first.
- DRAIN: read pointer starts at 0.
  - pv_valid=1 and pv_* = entry[ptr]. pv_last=1 when ptr==pv_cnt-1.
  - On pv_valid&&pv_ready the pointer increments. After the last handshake the FSM moves to DONE.
  - If pv_cnt==0, DRAIN lasts exactly one cycle with pv_valid=0, then moves to DONE.
- DONE: done=1; holds until col_start.
- Entry contents are preserved across DRAIN and DONE, so pv_cnt stays readable.

## Timing
- Reset values: flt_ready, np_valid, pv_valid, pv_last, overflow, busy and done are 0; pv_cnt=0; all np_*/pv_* data outputs are 0.
- Classification is single-cycle. A fault accepted at edge N is written at edge N and is visible to the compare for a fault accepted at edge N+1. Back-to-back faults on the same line classify correctly with no bubbles.
- np_valid is registered: it asserts for exactly one cycle, the cycle after accept. np_* are stable during that cycle.
- flt_ready falls the cycle after flt_end is sampled. pv_valid rises in that same first DRAIN cycle.
- pv_* are held stable while pv_valid && !pv_ready. pv_valid never drops without a handshake, except on col_start or reset.
- Throughput in DRAIN: one entry per cycle when pv_ready is held at 1.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at reset values, and no further handshakes. col_start mid-DRAIN aborts the stream; pv_valid is 0 on the next cycle.
- overflow is set on the cycle after the offending accept, and stays set until col_start or reset.

## Test plan
- Reset then col_start, then faults (5,7,b1), (5,9,b1), (3,7,b2), (5,7,b1) -> pv_cnt=2. One np pulse (idx0, 5,9,b1); (3,7,b2) is stored as entry1; the duplicate produces no pulse.
- Fault with flt_bnk=0 during COLLECT -> pv_cnt unchanged, no np pulse, overflow=0.
- Fill DEPTH=8 distinct pivots, then fault (100,200,b3) unrelated to any entry -> overflow=1 the next cycle, pv_cnt=8, the fault is not stored.
- flt_end with 3 entries while pv_ready toggles 1,0,0,1,1 -> entries stream out in order 0,1,2, with data held during stalls. pv_last is high only on entry2. done=1 the cycle after the final handshake.
- flt_end with pv_cnt=0 -> one DRAIN cycle with pv_valid=0, then done=1.
- Assert rst low mid-DRAIN, then release and col_start -> all outputs 0 during reset; the new collection starts with pv_cnt=0 and overflow=0.

Source files
------------

// File: rtl/pivot_fault_store.sv
// pivot_fault_store: classifies BIST fault reports into pivot / non-pivot /
// duplicate against a small pivot array, then streams the pivots downstream.
module pivot_fault_store #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BNK_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         col_start,
    input  logic                         flt_valid,
    output logic                         flt_ready,
    input  logic [ADDR_W-1:0]            flt_row,
    input  logic [ADDR_W-1:0]            flt_col,
    input  logic [BNK_W-1:0]             flt_bnk,
    input  logic                         flt_end,
    output logic                         np_valid,
    output logic [$clog2(DEPTH)-1:0]     np_idx,
    output logic [ADDR_W-1:0]            np_row,
    output logic [ADDR_W-1:0]            np_col,
    output logic [BNK_W-1:0]             np_bnk,
    output logic                         pv_valid,
    input  logic                         pv_ready,
    output logic [ADDR_W-1:0]            pv_row,
    output logic [ADDR_W-1:0]            pv_col,
    output logic [BNK_W-1:0]             pv_bnk,
    output logic                         pv_last,
    output logic [$clog2(DEPTH+1)-1:0]   pv_cnt,
    output logic                         overflow,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [BNK_W-1:0]  bnk;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             new_ent;
    entry_t             rd_ent;
    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               ovf_d;
    logic               accept, dup_hit, np_hit, full;
    logic               cls_np, cls_new, wr_en, set_ovf, hs;
    logic [IDX_W-1:0]   np_sel, wr_idx;
    logic               pv_valid_d, pv_last_d;

    // Compare the incoming fault against the stored pivots of the same bank
    always_comb begin
        new_ent = '{row: flt_row, col: flt_col, bnk: flt_bnk};
        accept  = flt_valid && flt_ready;
        dup_hit = 1'b0;
        np_hit  = 1'b0;
        np_sel  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < pv_cnt && ent_q[i].bnk == flt_bnk) begin
                if (ent_q[i].row == flt_row && ent_q[i].col == flt_col) begin
                    dup_hit = 1'b1;
                end
                if (!np_hit && (ent_q[i].row == flt_row || ent_q[i].col == flt_col)) begin
                    np_hit = 1'b1;
                    np_sel = IDX_W'(i);
                end
            end
        end
        full    = (pv_cnt == CNT_W'(DEPTH));
        cls_np  = accept && !col_start && (flt_bnk != '0) && !dup_hit && np_hit;
        cls_new = accept && !col_start && (flt_bnk != '0) && !dup_hit && !np_hit;
        wr_en   = cls_new && !full;
        set_ovf = cls_new && full;
        wr_idx  = IDX_W'(pv_cnt);
    end

    // Next state, counters and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = pv_cnt;
        ovf_d   = overflow;
        hs      = pv_valid && pv_ready;
        if (wr_en) begin
            cnt_d = pv_cnt + CNT_W'(1);
        end
        if (set_ovf) begin
            ovf_d = 1'b1;
        end
        case (state_q)
            S_COLLECT: begin
                if (flt_end) begin
                    state_d = S_DRAIN;
                    ptr_d   = '0;
                end
            end
            S_DRAIN: begin
                if (pv_cnt == '0) begin
                    state_d = S_DONE;
                end else if (hs) begin
                    if (pv_last) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
        if (col_start) begin
            state_d = S_COLLECT;
            ptr_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
        pv_valid_d = (state_d == S_DRAIN) && (CNT_W'(ptr_d) < cnt_d);
        pv_last_d  = pv_valid_d && (CNT_W'(ptr_d) == cnt_d - CNT_W'(1));
        // Bypass an entry being written this cycle so the first beat is correct
        rd_ent     = (wr_en && wr_idx == ptr_d) ? new_ent : ent_q[ptr_d];
        if (!pv_valid_d) begin
            rd_ent = '0;
        end
    end

    // State register and control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            pv_cnt    <= '0;
            overflow  <= 1'b0;
            flt_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pv_cnt    <= cnt_d;
            overflow  <= ovf_d;
            flt_ready <= (state_d == S_COLLECT);
            busy      <= (state_d == S_COLLECT) || (state_d == S_DRAIN);
            done      <= (state_d == S_DONE);
        end
    end

    // Pivot array: cleared banks mark entries empty, new pivots appended
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (col_start) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i].bnk <= '0;
            end
        end else if (wr_en) begin
            ent_q[wr_idx] <= new_ent;
        end
    end

    // Non-pivot report, one-cycle pulse after the accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            np_valid <= 1'b0;
            np_idx   <= '0;
            np_row   <= '0;
            np_col   <= '0;
            np_bnk   <= '0;
        end else begin
            np_valid <= cls_np;
            if (cls_np) begin
                np_idx <= np_sel;
                np_row <= flt_row;
                np_col <= flt_col;
                np_bnk <= flt_bnk;
            end
        end
    end

    // Readout port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_valid <= 1'b0;
            pv_last  <= 1'b0;
            pv_row   <= '0;
            pv_col   <= '0;
            pv_bnk   <= '0;
        end else begin
            pv_valid <= pv_valid_d;
            pv_last  <= pv_last_d;
            pv_row   <= rd_ent.row;
            pv_col   <= rd_ent.col;
            pv_bnk   <= rd_ent.bnk;
        end
    end

endmodule

// File: tb/tb_pivot_fault_store.sv
// tb_pivot_fault_store: directed and randomized checks against a queue-based
// model of pivot classification and readout.
module tb_pivot_fault_store;

    logic       clk, rst, col_start, flt_valid, flt_end, pv_ready;
    logic       flt_ready, np_valid, pv_valid, pv_last, overflow, busy, done;
    logic [9:0] flt_row, flt_col, np_row, np_col, pv_row, pv_col;
    logic [1:0] flt_bnk, np_bnk, pv_bnk;
    logic [2:0] np_idx;
    logic [3:0] pv_cnt;

    pivot_fault_store #(.DEPTH(8), .ADDR_W(10), .BNK_W(2)) dut (
        .clk(clk), .rst(rst), .col_start(col_start),
        .flt_valid(flt_valid), .flt_ready(flt_ready),
        .flt_row(flt_row), .flt_col(flt_col), .flt_bnk(flt_bnk), .flt_end(flt_end),
        .np_valid(np_valid), .np_idx(np_idx), .np_row(np_row), .np_col(np_col), .np_bnk(np_bnk),
        .pv_valid(pv_valid), .pv_ready(pv_ready), .pv_row(pv_row), .pv_col(pv_col),
        .pv_bnk(pv_bnk), .pv_last(pv_last), .pv_cnt(pv_cnt),
        .overflow(overflow), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int row;
        int col;
        int bnk;
    } ent_t;

    ent_t m_q[$];
    bit   m_ovf;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: 0 drop, 1 duplicate, 2 non-pivot, 3 stored, 4 overflow
    function automatic int classify(input int r, input int c, input int b, output int idx);
        idx = 0;
        if (b == 0) return 0;
        foreach (m_q[i]) if (m_q[i].row == r && m_q[i].col == c && m_q[i].bnk == b) return 1;
        foreach (m_q[i]) if (m_q[i].bnk == b && (m_q[i].row == r || m_q[i].col == c)) begin
            idx = i;
            return 2;
        end
        if (m_q.size() < 8) return 3;
        return 4;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_flt_ready"}, 32'(flt_ready), 0);
        chk({tag, "_np_valid"}, 32'(np_valid), 0);
        chk({tag, "_np_data"}, {np_idx, np_row, np_col, np_bnk}, 0);
        chk({tag, "_pv_valid"}, 32'(pv_valid), 0);
        chk({tag, "_pv_data"}, {pv_row, pv_col, pv_bnk, pv_last}, 0);
        chk({tag, "_pv_cnt"}, 32'(pv_cnt), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_busy_done"}, {busy, done}, 0);
    endtask

    task automatic start();
        col_start = 1'b1;
        flt_valid = 1'b0;
        flt_end   = 1'b0;
        @(negedge clk);
        col_start = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        chk("start_ready", 32'(flt_ready), 1);
        chk("start_busy", {busy, done, pv_valid}, 3'b100);
        chk("start_cnt", 32'(pv_cnt), 0);
        chk("start_ovf", 32'(overflow), 0);
    endtask

    // One fault per cycle; inputs left asserted so calls run back to back
    task automatic send(input int r, input int c, input int b, input bit fend);
        int   idx, kind;
        ent_t e;
        kind = classify(r, c, b, idx);
        flt_valid = 1'b1;
        flt_row   = 10'(r);
        flt_col   = 10'(c);
        flt_bnk   = 2'(b);
        flt_end   = fend;
        @(negedge clk);
        if (kind == 3) begin
            e.row = r; e.col = c; e.bnk = b;
            m_q.push_back(e);
        end
        if (kind == 4) m_ovf = 1'b1;
        chk("np_valid", 32'(np_valid), 32'(kind == 2));
        if (kind == 2) chk("np_data", {np_idx, np_row, np_col, np_bnk}, {3'(idx), 10'(r), 10'(c), 2'(b)});
        chk("pv_cnt", 32'(pv_cnt), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("flt_ready", 32'(flt_ready), 32'(!fend));
    endtask

    task automatic idle();
        flt_valid = 1'b0;
        flt_end   = 1'b0;
        @(negedge clk);
        chk("idle_np", 32'(np_valid), 0);
    endtask

    // Called at the first DRAIN sample point; pat[k] is pv_ready in cycle k
    task automatic drain(input logic [31:0] pat);
        int p   = 0;
        int cnt = m_q.size();
        bit fin = 1'b0;
        flt_valid = 1'b0;
        flt_end   = 1'b0;
        chk("drain_busy", {busy, flt_ready}, 2'b10);
        if (cnt == 0) begin
            chk("empty_drain", {pv_valid, done}, 2'b00);
            pv_ready = 1'b1;
            @(negedge clk);
            chk("empty_done", {pv_valid, done, busy}, 3'b010);
            pv_ready = 1'b0;
            return;
        end
        for (int k = 0; k < 64 && !fin; k++) begin
            if (p < cnt) begin
                chk("pv_valid", {pv_valid, done}, 2'b10);
                chk("pv_data", {pv_row, pv_col, pv_bnk},
                    {10'(m_q[p].row), 10'(m_q[p].col), 2'(m_q[p].bnk)});
                chk("pv_last", 32'(pv_last), 32'(p == cnt - 1));
            end else begin
                chk("drain_done", {pv_valid, done, busy}, 3'b010);
                chk("done_cnt", 32'(pv_cnt), 32'(cnt));
                fin = 1'b1;
            end
            if (!fin) begin
                pv_ready = (k < 32) ? pat[k] : 1'b1;
                @(negedge clk);
                if (pv_ready) p++;
            end
        end
        if (!fin) chk("drain_timeout", 0, 1);
        pv_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; col_start = 1'b0; flt_valid = 1'b0; flt_end = 1'b0; pv_ready = 1'b0;
        flt_row = '0; flt_col = '0; flt_bnk = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {flt_ready, busy, done}, 0);

        // Basic classification
        start();
        send(5, 7, 1, 0);
        send(5, 9, 1, 0);
        send(3, 7, 2, 0);
        send(5, 7, 1, 0);
        idle();
        chk("basic_cnt", 32'(pv_cnt), 2);
        send(9, 9, 0, 0);
        idle();

        // Fill, then overflow
        start();
        for (int i = 0; i < 8; i++) send(i, 16 + i, 1, 0);
        send(100, 200, 3, 0);
        idle();
        chk("full_ovf", {overflow, pv_cnt}, {1'b1, 4'd8});
        send(1, 300, 1, 0);
        idle();

        // Three-entry drain with stalls; third fault classified with flt_end
        start();
        send(11, 21, 2, 0);
        send(12, 22, 3, 0);
        send(13, 23, 1, 1);
        drain(32'b11001);
        @(negedge clk);
        chk("done_hold", {done, pv_valid}, 2'b10);

        // Empty drain
        start();
        flt_end = 1'b1;
        @(negedge clk);
        drain(32'hffff_ffff);

        // Randomized collection and drain
        start();
        for (int i = 0; i < 40; i++)
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), i == 39);
        drain($urandom);

        // Reset in the middle of a drain
        start();
        send(40, 50, 1, 0);
        send(41, 51, 2, 1);
        flt_valid = 1'b0;
        flt_end   = 1'b0;
        chk("pre_rst_valid", 32'(pv_valid), 1);
        pv_ready = 1'b1;
        #2 rst = 1'b0;
        #1 chk_reset("mid_rst");
        @(negedge clk);
        chk_reset("mid_rst_hold");
        pv_ready = 1'b0;
        rst = 1'b1;
        start();
        send(60, 70, 3, 0);
        idle();
        chk("post_rst_cnt", {overflow, pv_cnt}, {1'b0, 4'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
